// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: state codes, widths and default bit time.
// The receiver uses the same state codes and default CLKS_PER_BIT.
package uart_tx_pkg;

  localparam int DATA_W           = 8;
  localparam int TICK_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 40;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time tick counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clr_i is high so every bit period starts from a clean count.
module uart_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

  assign tc_o = (tick_cnt_q == LAST_TICK);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (clr_i || tc_o) tick_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, one bit every CLKS_PER_BIT clocks on an idle-high line.
// state | meaning: IDLE line high, wait tx_start | START start bit | DATA 8 data bits | STOP stop bit
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] din,
  output logic              Tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  logic [2:0] state_q, state_d;
  data_t      shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       bit_tc;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == ST_IDLE),
    .tc_o (bit_tc)
  );

  // The shift register is consumed from bit 0, so each bit time shifts it right once.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        bit_idx_d = '0;
        if (tx_start) begin
          shift_d = din;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_tc) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tc) begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end else begin
            bit_idx_d = '0;
            tx_d      = 1'b1;
            state_d   = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_tc) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign Tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done_q;

endmodule
